phase_inc_estimator: RTL and testbench

- Inverse of the NCO phase accumulator: measures the period of an incoming pulse/square signal (e.g. an NCO `tick`) and recovers the equivalent phase increment.
- Result: phase_inc = floor(2^AVG_LOG2 · 2^PHASE_WIDTH / C), where C = clk cycles spanning 2^AVG_LOG2 input periods.
- Used for loopback checking of the NCO and for frequency-locking against external references.

---
 rtl/phase_pkg.sv | 23 ++
 rtl/seq_divider.sv | 60 ++++++
 rtl/phase_inc_estimator.sv | 114 +++++++++++
 tb/tb_phase_inc_estimator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared definitions for the phase increment estimator and its sequential divider.
package phase_pkg;

  localparam int DEFAULT_PHASE_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DIVIDE  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Bits needed to hold value-1; never below 1 so degenerate counters keep a bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; numer bits above Q_WIDTH must be below denom.
module seq_divider
  import phase_pkg::*;
#(
  parameter int N_WIDTH = 35,
  parameter int D_WIDTH = 25,
  parameter int Q_WIDTH = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] numer,
  input  logic [D_WIDTH-1:0] denom,
  output logic               done,
  output logic [Q_WIDTH-1:0] quotient
);

  localparam int STEP_W = clog2(Q_WIDTH);

  logic              running;
  logic [STEP_W-1:0] step;
  logic [D_WIDTH-1:0] rem;
  logic [D_WIDTH-1:0] den;
  logic [Q_WIDTH-1:0] num_sh;
  logic [D_WIDTH:0]   trial;
  logic               q_bit;
  logic [D_WIDTH-1:0] rem_next;

  // quotient shows the value after the current step, so it is final in the done cycle
  always_comb begin
    trial    = {rem, num_sh[Q_WIDTH-1]};
    q_bit    = (trial >= {1'b0, den});
    rem_next = q_bit ? D_WIDTH'(trial - {1'b0, den}) : D_WIDTH'(trial);
    quotient = (num_sh << 1) | Q_WIDTH'(q_bit);
  end

  assign done = running && (step == STEP_W'(Q_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      step    <= '0;
      rem     <= '0;
      den     <= '0;
      num_sh  <= '0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
      rem     <= D_WIDTH'(numer >> Q_WIDTH);
      den     <= denom;
      num_sh  <= numer[Q_WIDTH-1:0];
    end else if (running) begin
      rem    <= rem_next;
      num_sh <= quotient;
      step   <= step + STEP_W'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_inc_estimator.sv
// Measures the period of sig_in over 2^AVG_LOG2 rising edges and recovers the NCO phase increment.
module phase_inc_estimator
  import phase_pkg::*;
#(
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int CNT_WIDTH   = 24,
  parameter int AVG_LOG2    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sig_in,
  output logic [PHASE_WIDTH-1:0] phase_inc,
  output logic                   valid,
  output logic                   timeout,
  output logic                   busy
);

  localparam int AVG     = 1 << AVG_LOG2;
  localparam int EDGE_W  = clog2(AVG);
  localparam int N_WIDTH = PHASE_WIDTH + AVG_LOG2 + 1;
  localparam int D_WIDTH = CNT_WIDTH + 1;
  localparam int Q_WIDTH = PHASE_WIDTH + 1;
  localparam logic [N_WIDTH-1:0] DIV_NUMER = N_WIDTH'(1) << (PHASE_WIDTH + AVG_LOG2);

  state_t               state;
  state_t               state_next;
  logic                 sig_d;
  logic                 rise;
  logic                 complete;
  logic                 expire;
  logic                 div_done;
  logic [CNT_WIDTH-1:0] cnt;
  logic [EDGE_W-1:0]    edges;
  logic [Q_WIDTH-1:0]   quotient;

  // A completing rise on the last counter value still wins over the timeout.
  assign rise     = sig_in & ~sig_d;
  assign complete = (state == ST_MEASURE) && en && rise && (edges == EDGE_W'(AVG - 1));
  assign expire   = (state == ST_MEASURE) && en && !complete && (cnt == '1);
  assign busy     = (state == ST_MEASURE) || (state == ST_DIVIDE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (en && rise) state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (!en || expire) state_next = ST_IDLE;
        else if (complete) state_next = ST_DIVIDE;
      end
      ST_DIVIDE:  if (div_done) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d     <= 1'b1;
      cnt       <= '0;
      edges     <= '0;
      phase_inc <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      sig_d   <= sig_in;
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && rise) begin
            cnt   <= '0;
            edges <= '0;
          end
        end
        ST_MEASURE: begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (en && rise && !complete) edges <= edges + EDGE_W'(1);
          if (expire) begin
            timeout   <= 1'b1;
            phase_inc <= '0;
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            valid     <= 1'b1;
            phase_inc <= quotient[PHASE_WIDTH] ? '1 : quotient[PHASE_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  seq_divider #(
    .N_WIDTH(N_WIDTH),
    .D_WIDTH(D_WIDTH),
    .Q_WIDTH(Q_WIDTH)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .start   (complete),
    .numer   (DIV_NUMER),
    .denom   (D_WIDTH'(cnt) + D_WIDTH'(1)),
    .done    (div_done),
    .quotient(quotient)
  );

endmodule

// File: tb/tb_phase_inc_estimator.sv
// Randomized pulse trains checked against an arithmetic model: phase_inc = floor(2^(PW+AL) / C).
module tb_phase_inc_estimator;

  localparam int PW = 32;
  localparam int CW = 8;
  localparam int AL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          sig_in = 1'b1;
  logic [PW-1:0] phase_inc;
  logic          valid;
  logic          timeout;
  logic          busy;

  phase_inc_estimator #(
    .PHASE_WIDTH(PW),
    .CNT_WIDTH  (CW),
    .AVG_LOG2   (AL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sig_in   (sig_in),
    .phase_inc(phase_inc),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            compared = 0;
  int            mismatched = 0;
  int            validCount = 0;
  int            timeoutCount = 0;
  int            busyCount = 0;
  int            overlapCount = 0;
  int            lastValidCyc = -1000;
  int            lastTimeoutCyc = -1000;
  logic [PW-1:0] lastValidVal = '0;
  logic [PW-1:0] expPhase = '0;
  logic          enReq = 1'b1;
  logic          rstReq = 1'b1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs just after the edge, sample outputs on the falling edge.
  task automatic applyStimulus(input logic sigv);
    @(posedge clk);
    #1;
    sig_in = sigv;
    en     = enReq;
    rst    = rstReq;
    @(negedge clk);
    if (valid === 1'b1) begin
      validCount++;
      lastValidCyc = cyc;
      lastValidVal = phase_inc;
    end
    if (timeout === 1'b1) begin
      timeoutCount++;
      lastTimeoutCyc = cyc;
    end
    if (valid === 1'b1 && timeout === 1'b1) overlapCount++;
    if (busy === 1'b1) busyCount++;
  endtask

  function automatic logic [PW-1:0] refPhaseInc(input int c);
    longint q;
    q = (longint'(1) << (PW + AL)) / longint'(c);
    if (q >= (longint'(1) << PW)) q = (longint'(1) << PW) - 1;
    return PW'(q);
  endfunction

  // Start rise, four periods, then the completing rise whose cycle is returned.
  task automatic driveTrain(input int per[4], input int hw, output int edgeCyc);
    for (int i = 0; i < 4; i++) begin
      int h;
      h = (hw < per[i]) ? hw : per[i] - 1;
      for (int k = 0; k < per[i]; k++) applyStimulus(logic'(k < h));
    end
    applyStimulus(1'b1);
    edgeCyc = cyc;
  endtask

  task automatic runMeasurement(input string tag, input int per[4], input int hw, input bit noise);
    int e, c, v0, t0, b0;
    logic [PW-1:0] expVal;
    c = per[0] + per[1] + per[2] + per[3];
    expVal = refPhaseInc(c);
    v0 = validCount;
    t0 = timeoutCount;
    b0 = busyCount;
    driveTrain(per, hw, e);
    checkOutput({tag, "_busy_measure"}, busyCount - b0, c);
    b0 = busyCount;
    for (int k = 1; k <= 45; k++)
      applyStimulus((noise && k <= 32) ? 1'($urandom_range(0, 1)) : 1'b0);
    checkOutput({tag, "_valid_count"}, validCount - v0, 1);
    checkOutput({tag, "_latency"}, lastValidCyc - e, PW + 2);
    checkOutput({tag, "_phase_inc"}, lastValidVal, expVal);
    checkOutput({tag, "_busy_divide"}, busyCount - b0, PW + 1);
    checkOutput({tag, "_no_timeout"}, timeoutCount - t0, 0);
    expPhase = expVal;
  endtask

  initial begin
    int s, e, v0, t0, b0, nPrev;
    int per[4];
    logic [31:0] acc;

    repeat (3) applyStimulus(1'b1);
    checkOutput("reset_phase_inc", phase_inc, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_timeout", timeout, 0);
    checkOutput("reset_busy", busy, 0);

    rstReq = 1'b0;
    b0 = busyCount;
    repeat (6) applyStimulus(1'b1);
    checkOutput("held_high_no_start", busyCount - b0, 0);
    repeat (3) applyStimulus(1'b0);

    runMeasurement("period10", '{10, 10, 10, 10}, 1, 1'b0);
    runMeasurement("period2", '{2, 2, 2, 2}, 1, 1'b0);
    runMeasurement("period3", '{3, 3, 3, 3}, 1, 1'b0);
    runMeasurement("period3_wide", '{3, 3, 3, 3}, 2, 1'b1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) per[i] = $urandom_range(2, 50);
      runMeasurement("random", per, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 5)) applyStimulus(1'b0);
    end

    // Single rise then silence: the counter must run out.
    v0 = validCount;
    t0 = timeoutCount;
    applyStimulus(1'b1);
    s = cyc;
    repeat (299) applyStimulus(1'b0);
    checkOutput("timeout_count", timeoutCount - t0, 1);
    checkOutput("timeout_cycle", lastTimeoutCyc - s, (1 << CW) + 1);
    checkOutput("timeout_phase_inc", phase_inc, 0);
    checkOutput("timeout_no_valid", validCount - v0, 0);
    checkOutput("timeout_idle", busy, 0);

    runMeasurement("refill", '{7, 9, 11, 13}, 3, 1'b1);

    // Drop en partway through a measurement.
    v0 = validCount;
    t0 = timeoutCount;
    applyStimulus(1'b1);
    repeat (9) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (4) applyStimulus(1'b0);
    enReq = 1'b0;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("en_drop_busy", busy, 0);
    for (int k = 0; k < 20; k++) applyStimulus(logic'(k % 5 == 0));
    enReq = 1'b1;
    repeat (300) applyStimulus(1'b0);
    checkOutput("en_drop_no_valid", validCount - v0, 0);
    checkOutput("en_drop_no_timeout", timeoutCount - t0, 0);
    checkOutput("en_drop_phase_held", phase_inc, expPhase);

    // Reset while the divider is running.
    v0 = validCount;
    t0 = timeoutCount;
    driveTrain('{10, 10, 10, 10}, 1, e);
    repeat (10) applyStimulus(1'b0);
    rstReq = 1'b1;
    repeat (2) applyStimulus(1'b0);
    rstReq = 1'b0;
    b0 = busyCount;
    repeat (50) applyStimulus(1'b0);
    checkOutput("rst_divide_no_valid", validCount - v0, 0);
    checkOutput("rst_divide_no_timeout", timeoutCount - t0, 0);
    checkOutput("rst_divide_phase_inc", phase_inc, 0);
    checkOutput("rst_divide_idle", busyCount - b0, 0);

    runMeasurement("post_rst", '{10, 10, 10, 10}, 1, 1'b0);

    // Loopback from an NCO accumulator MSB, nominal period 10.
    acc = '0;
    v0 = validCount;
    for (int k = 0; k < 200; k++) begin
      nPrev = validCount;
      acc = acc + 32'h1999_999A;
      applyStimulus(acc[31]);
      if (validCount != nPrev) checkOutput("loopback_phase_inc", lastValidVal, 32'h1999_9999);
    end
    checkOutput("loopback_valids", logic'((validCount - v0) >= 2), 1);

    checkOutput("valid_timeout_exclusive", overlapCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
